message_receiver: RTL and testbench
===================================

Name: message_receiver

Overview:
- Far end of the 9-bit secret-message stream. The transmitter side outputs one message word per clock while its enable is high, and restarts from word 0 when the enable drops.
- This block drives that enable and captures words until the end-of-message flag (bit 8).
- Stores the 8-bit characters in a local buffer and reports length, running checksum and overflow.
- Provides a synchronous readback port for the host/logic-analyser side of the harness.

Parameters:
- DEPTH, 256, buffer capacity in characters; power of two, 2..256.
- ADDR_W, 8, log2(DEPTH); width of rd_addr_i.
- LATENCY, 0, number of pipeline stages between stream_en_o and rx_data_i. Words arriving in the first LATENCY enabled cycles are discarded.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  capture request; sampled only in IDLE or DONE.
- stream_en_o  out  1  transmitter enable; registered output.
- rx_data_i  in  9  incoming word; [7:0] = character, [8] = end-of-message flag.
- busy_o  out  1  high in SKIP or CAPTURE.
- done_o  out  1  high in DONE.
- msg_len_o  out  ADDR_W+1  number of characters stored.
- overflow_o  out  1  buffer filled before the end-of-message flag was seen.
- checksum_o  out  8  sum modulo 256 of the stored characters.
- rd_addr_i  in  ADDR_W  readback address.
- rd_data_o  out  8  buffer contents at rd_addr_i; one-cycle latency.

Behaviour:
- Reset (rst_i high at an edge): state IDLE; stream_en_o, busy_o, done_o, overflow_o = 0; msg_len_o = 0; checksum_o = 0.
  - rd_data_o resets to 0.
  - Buffer contents are not cleared.
  - Reset takes priority over every other event, including mid-capture: the enable drops on the same edge.
- States: IDLE, SKIP, CAPTURE, DONE. stream_en_o = 1 exactly in SKIP and CAPTURE.
- IDLE/DONE, start_i = 1 at edge N:
  - Clear msg_len_o, checksum_o, overflow_o.
  - Enter SKIP if LATENCY > 0, otherwise CAPTURE.
  - stream_en_o is high from after edge N.
- SKIP: count LATENCY edges with rx_data_i ignored, then enter CAPTURE.
- CAPTURE: word k (k from 0) is sampled at edge N+1+LATENCY+k, with no gaps.
  - Each sampled word writes bit[7:0] to buffer[msg_len], increments msg_len and adds the character to checksum (8-bit wrap).
- Termination is evaluated on the same edge as the write:
  - bit 8 = 1 → store the character, go to DONE. The flagged character counts in the length.
  - bit 8 = 0 and msg_len becomes DEPTH → store, set overflow_o, go to DONE.
  - If both occur on the same edge: store and go to DONE with overflow_o = 0.
  - stream_en_o is low after the terminating edge, so the transmitter rewinds to word 0.
- start_i during SKIP/CAPTURE is ignored. A start_i held high in DONE begins a new capture on the next edge.
- msg_len_o width is ADDR_W+1, so DEPTH = 256 reports 256 without wrap.
- Readback:
  - rd_data_o <= buffer[rd_addr_i] on every edge, in any state.
  - Same-address read during a write returns the old data.
  - Addresses at or above msg_len_o return stale contents.

Decomposition:
- Package message_pkg:
  - state enum {IDLE, SKIP, CAPTURE, DONE};
  - EOM_BIT = 8, CHAR_W = 8, WORD_W = 9;
  - default DEPTH constant.
- Sub-module message_buffer: 1-write/1-read synchronous RAM, DEPTH x 8, registered read, read-old-on-collision.
  - Kept separate so it can map to a memory macro.

Test Plan:
- Reset then idle: no start_i for 10 cycles → stream_en_o = 0, busy_o = 0, done_o = 0, msg_len_o = 0, checksum_o = 0.
- LATENCY = 0, start_i at edge 5, transmitter model sends 0x048 'H', 0x049 'I', 0x121 ('!' + EOM):
  - done_o rises after edge 8;
  - msg_len_o = 3, checksum_o = 0xB2, overflow_o = 0;
  - stream_en_o high for exactly 3 cycles;
  - readback addresses 0..2 = 0x48, 0x49, 0x21.
- LATENCY = 2, same message behind a 2-stage delay → identical results; busy_o high for 5 cycles.
- DEPTH = 4, stream 0x01..0x06 with no EOM → msg_len_o = 4, overflow_o = 1, checksum_o = 0x0A, stream_en_o low after word 4.
- Edge cases:
  - DEPTH = 4, EOM on word 4 → overflow_o = 0.
  - rst_i asserted on word 2 of capture → all outputs at reset values next cycle, stream_en_o low.
  - A later start_i recaptures from length 0.
- start_i pulsed during CAPTURE is ignored (length unchanged). start_i in DONE clears status and recaptures the same message, giving identical checksum.

Source files
------------

// File: rtl/message_pkg.sv
// -----------------------------------------------------------------------------
// message_pkg
// Shared types and constants for the secret-message receiver slice.
//
// Contents:
//   state_t        receiver FSM states (IDLE, SKIP, CAPTURE, DONE)
//   EOM_BIT        index of the end-of-message flag inside a stream word
//   CHAR_W         width of one stored character
//   WORD_W         width of one stream word (character + flag)
//   DEFAULT_DEPTH  default buffer capacity in characters
//   addChar()      8-bit wrapping checksum accumulate
// -----------------------------------------------------------------------------
package message_pkg;

    // Receiver control states. IDLE and DONE both accept a new start request;
    // SKIP swallows the words still in flight through the stream pipeline.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int EOM_BIT       = 8;
    localparam int CHAR_W        = 8;
    localparam int WORD_W        = 9;
    localparam int DEFAULT_DEPTH = 256;

    // The checksum is a plain modulo-256 sum, so the carry is simply dropped.
    function automatic logic [CHAR_W-1:0] addChar(input logic [CHAR_W-1:0] sum,
                                                  input logic [CHAR_W-1:0] ch);
        return sum + ch;
    endfunction

endpackage

// File: rtl/message_buffer.sv
// -----------------------------------------------------------------------------
// message_buffer
// Single-write / single-read synchronous character store with a registered
// read port. A read of the address being written on the same edge returns the
// previous contents. Storage itself has no reset so it can map onto a memory
// macro; only the read register is cleared.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset (read register only)
//   i_wrEn    write strobe
//   i_wrAddr  write address
//   i_wrData  character to store
//   i_rdAddr  read address
//   o_rdData  contents at i_rdAddr, valid one cycle after the address
// -----------------------------------------------------------------------------
module message_buffer
    import message_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [CHAR_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [CHAR_W-1:0] o_rdData
);

    logic [CHAR_W-1:0] r_mem [DEPTH];
    logic [CHAR_W-1:0] r_rdData;

    // Write port. Deliberately reset-free: the array contents survive a reset
    // so the host can still inspect the last message afterwards.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Registered read. Because both ports update with non-blocking
    // assignments, a same-address collision naturally returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/message_receiver.sv
// -----------------------------------------------------------------------------
// message_receiver
// Far end of the 9-bit secret-message stream. Drives the transmitter enable,
// discards the words still in the delivery pipeline, then stores characters
// until the end-of-message flag arrives or the buffer fills. Reports length,
// running checksum and overflow, and offers a synchronous readback port.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      capture request, honoured only in IDLE or DONE
//   stream_en_o  transmitter enable (registered)
//   rx_data_i    incoming word: [7:0] character, [8] end-of-message
//   busy_o       high while skipping or capturing
//   done_o       high once a message has been captured
//   msg_len_o    number of characters stored (0..DEPTH)
//   overflow_o   buffer filled before the end-of-message flag
//   checksum_o   modulo-256 sum of stored characters
//   rd_addr_i    readback address
//   rd_data_o    buffer contents at rd_addr_i, one-cycle latency
// -----------------------------------------------------------------------------
module message_receiver
    import message_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LATENCY = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              stream_en_o,
    input  logic [WORD_W-1:0] rx_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   msg_len_o,
    output logic              overflow_o,
    output logic [CHAR_W-1:0] checksum_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [CHAR_W-1:0] rd_data_o
);

    // The skip counter only needs to reach LATENCY-1; keep it at least one bit
    // wide so the LATENCY = 0 build still has a legal (unused) register.
    localparam int SKIP_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SKIP_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [ADDR_W:0] LEN_LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [SKIP_W-1:0]   r_skipCnt;
    logic                r_streamEn;
    logic [ADDR_W:0]     r_msgLen;
    logic [CHAR_W-1:0]   r_checksum;
    logic                r_overflow;

    logic                w_isEom;
    logic                w_isLast;
    logic                w_skipDone;
    logic                w_startAccept;
    logic                w_wrEn;
    logic                w_busy;
    logic                w_done;
    logic                w_enNext;
    logic [CHAR_W-1:0]   w_char;

    assign w_char     = rx_data_i[CHAR_W-1:0];
    assign w_isEom    = rx_data_i[EOM_BIT];
    // The write happening this edge is the one that makes the buffer full.
    assign w_isLast   = (r_msgLen == LEN_LAST);
    assign w_skipDone = (r_skipCnt == SKIP_W'(SKIP_LAST));

    // State register. Reset wins over everything, including a capture that is
    // halfway through a message.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. With no pipeline latency the SKIP state is bypassed
    // entirely so word 0 is sampled on the very next edge after the start.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_nextState = (LATENCY > 0) ? SKIP : CAPTURE;
                end
            end
            SKIP: begin
                if (w_skipDone) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_isEom || w_isLast) begin
                    w_nextState = DONE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output decode. The enable is computed from the next state so that the
    // registered copy is high exactly while the FSM sits in SKIP or CAPTURE,
    // and drops on the same edge that terminates the message.
    always_comb begin
        w_startAccept = 1'b0;
        w_wrEn        = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                w_startAccept = start_i;
            end
            DONE: begin
                w_startAccept = start_i;
                w_done        = 1'b1;
            end
            SKIP: begin
                w_busy = 1'b1;
            end
            CAPTURE: begin
                w_busy = 1'b1;
                w_wrEn = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
        w_enNext = (w_nextState == SKIP) || (w_nextState == CAPTURE);
    end

    // Counts the edges spent in SKIP; parked at zero in every other state so
    // each capture starts counting afresh.
    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != SKIP)) begin
            r_skipCnt <= '0;
        end else begin
            r_skipCnt <= r_skipCnt + 1'b1;
        end
    end

    // Registered transmitter enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_streamEn <= 1'b0;
        end else begin
            r_streamEn <= w_enNext;
        end
    end

    // Message status. A start clears the previous result; every captured word
    // bumps the length and checksum. Overflow is only flagged when the buffer
    // fills on a word that is not itself the end of the message.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_msgLen   <= '0;
            r_checksum <= '0;
            r_overflow <= 1'b0;
        end else if (w_startAccept) begin
            r_msgLen   <= '0;
            r_checksum <= '0;
            r_overflow <= 1'b0;
        end else if (w_wrEn) begin
            r_msgLen   <= r_msgLen + 1'b1;
            r_checksum <= addChar(r_checksum, w_char);
            r_overflow <= w_isLast && !w_isEom;
        end
    end

    message_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (r_msgLen[ADDR_W-1:0]),
        .i_wrData (w_char),
        .i_rdAddr (rd_addr_i),
        .o_rdData (rd_data_o)
    );

    assign stream_en_o = r_streamEn;
    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign msg_len_o   = r_msgLen;
    assign overflow_o  = r_overflow;
    assign checksum_o  = r_checksum;

endmodule

// File: tb/tb_message_receiver.sv
// -----------------------------------------------------------------------------
// tb_message_receiver
// Three receivers side by side: LATENCY 0 / DEPTH 256, LATENCY 2 / DEPTH 256
// and LATENCY 0 / DEPTH 4, each fed by its own small transmitter model that
// emits one word per enabled cycle and rewinds when its enable drops.
// -----------------------------------------------------------------------------
module tb_message_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start  [3];
    logic       en     [3];
    logic       busy   [3];
    logic       done   [3];
    logic       ovf    [3];
    logic [8:0] len    [3];
    logic [7:0] cks    [3];
    logic [7:0] rd     [3];
    logic [7:0] rdAddr [3];
    logic [8:0] rx     [3];
    logic [2:0] len4;

    int total = 0;
    int bad   = 0;
    int sel4  = 0;

    logic [8:0] msgA   [8];
    logic [8:0] msgOvf [8];
    logic [8:0] msgEom [8];
    logic [2:0] idx    [3];
    logic [8:0] pipe1, pipe2;

    // 100 MHz-style free running clock.
    always #5 clk = ~clk;

    // Transmitter models: word index advances on each enabled edge and goes
    // back to zero whenever the enable is low.
    always @(posedge clk) begin
        idx[0] <= (rst || !en[0]) ? 3'd0 : idx[0] + 3'd1;
        idx[1] <= (rst || !en[1]) ? 3'd0 : idx[1] + 3'd1;
        idx[2] <= (rst || !en[2]) ? 3'd0 : idx[2] + 3'd1;
    end

    // Two-stage delivery pipeline in front of the LATENCY = 2 receiver.
    always @(posedge clk) begin
        pipe1 <= msgA[idx[1]];
        pipe2 <= pipe1;
    end

    assign rx[0]  = msgA[idx[0]];
    assign rx[1]  = pipe2;
    assign rx[2]  = (sel4 == 0) ? msgOvf[idx[2]] : msgEom[idx[2]];
    assign len[2] = {6'd0, len4};

    message_receiver #(.DEPTH(256), .ADDR_W(8), .LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .stream_en_o(en[0]),
        .rx_data_i(rx[0]), .busy_o(busy[0]), .done_o(done[0]),
        .msg_len_o(len[0]), .overflow_o(ovf[0]), .checksum_o(cks[0]),
        .rd_addr_i(rdAddr[0]), .rd_data_o(rd[0])
    );

    message_receiver #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .stream_en_o(en[1]),
        .rx_data_i(rx[1]), .busy_o(busy[1]), .done_o(done[1]),
        .msg_len_o(len[1]), .overflow_o(ovf[1]), .checksum_o(cks[1]),
        .rd_addr_i(rdAddr[1]), .rd_data_o(rd[1])
    );

    message_receiver #(.DEPTH(4), .ADDR_W(2), .LATENCY(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .stream_en_o(en[2]),
        .rx_data_i(rx[2]), .busy_o(busy[2]), .done_o(done[2]),
        .msg_len_o(len4), .overflow_o(ovf[2]), .checksum_o(cks[2]),
        .rd_addr_i(rdAddr[2][1:0]), .rd_data_o(rd[2])
    );

    typedef struct {
        string name;
        int    dut;
        int    msgSel;
        int    expLen;
        int    expCks;
        int    expOvf;
        int    expEn;
        int    expBusy;
    } capVec_t;

    typedef struct {
        int dut;
        int addr;
        int expData;
    } rdVec_t;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start for one edge, then follows the capture until done_o,
    // counting the sampled cycles with the enable and busy high.
    task automatic applyStimulus(input int d, output int enCnt, output int busyCnt,
                                 output int gotDone);
        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
        enCnt   = 0;
        busyCnt = 0;
        gotDone = 0;
        for (int c = 0; c < 40 && gotDone == 0; c++) begin
            if (en[d])   enCnt++;
            if (busy[d]) busyCnt++;
            if (done[d]) gotDone = 1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic waitDone(input int d, output int gotDone);
        gotDone = 0;
        for (int c = 0; c < 40 && gotDone == 0; c++) begin
            if (done[d]) gotDone = 1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        capVec_t vecs [5];
        rdVec_t  rds  [7];
        int enCnt, busyCnt, gotDone;

        msgA   = '{9'h048, 9'h049, 9'h121, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        msgOvf = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h000, 9'h000};
        msgEom = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h000, 9'h000, 9'h000, 9'h000};

        vecs[0] = '{"lat0 HI!",      0, 0, 3, 'hB2, 0, 3, 3};
        vecs[1] = '{"lat2 HI!",      1, 0, 3, 'hB2, 0, 5, 5};
        vecs[2] = '{"depth4 ovf",    2, 0, 4, 'h0A, 1, 4, 4};
        vecs[3] = '{"depth4 eom@4",  2, 1, 4, 'h0A, 0, 4, 4};
        vecs[4] = '{"lat0 recapture", 0, 0, 3, 'hB2, 0, 3, 3};

        rds[0] = '{0, 0, 'h48};
        rds[1] = '{0, 1, 'h49};
        rds[2] = '{0, 2, 'h21};
        rds[3] = '{1, 2, 'h21};
        rds[4] = '{2, 0, 'h01};
        rds[5] = '{2, 1, 'h02};
        rds[6] = '{2, 3, 'h04};

        // Reset, then sit idle for ten cycles.
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d]  = 1'b0;
            rdAddr[d] = 8'd0;
        end
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset rd_data", int'(rd[0]), 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("idle%0d stream_en", d), int'(en[d]), 0);
            checkOutput($sformatf("idle%0d busy", d), int'(busy[d]), 0);
            checkOutput($sformatf("idle%0d done", d), int'(done[d]), 0);
            checkOutput($sformatf("idle%0d len", d), int'(len[d]), 0);
            checkOutput($sformatf("idle%0d cks", d), int'(cks[d]), 0);
            checkOutput($sformatf("idle%0d ovf", d), int'(ovf[d]), 0);
        end

        // Table of complete captures.
        foreach (vecs[i]) begin
            sel4 = vecs[i].msgSel;
            applyStimulus(vecs[i].dut, enCnt, busyCnt, gotDone);
            checkOutput({vecs[i].name, " done"}, gotDone, 1);
            checkOutput({vecs[i].name, " len"}, int'(len[vecs[i].dut]), vecs[i].expLen);
            checkOutput({vecs[i].name, " cks"}, int'(cks[vecs[i].dut]), vecs[i].expCks);
            checkOutput({vecs[i].name, " ovf"}, int'(ovf[vecs[i].dut]), vecs[i].expOvf);
            checkOutput({vecs[i].name, " en cycles"}, enCnt, vecs[i].expEn);
            checkOutput({vecs[i].name, " busy cycles"}, busyCnt, vecs[i].expBusy);
            checkOutput({vecs[i].name, " en after"}, int'(en[vecs[i].dut]), 0);
        end

        // Readback of stored characters.
        foreach (rds[i]) begin
            rdAddr[rds[i].dut] = 8'(rds[i].addr);
            @(posedge clk); #1;
            checkOutput($sformatf("readback dut%0d[%0d]", rds[i].dut, rds[i].addr),
                        int'(rd[rds[i].dut]), rds[i].expData);
        end

        // Start pulsed mid-capture on the delayed receiver is ignored.
        @(posedge clk); #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        waitDone(1, gotDone);
        checkOutput("start-in-capture done", gotDone, 1);
        checkOutput("start-in-capture len", int'(len[1]), 3);
        checkOutput("start-in-capture cks", int'(cks[1]), 'hB2);

        // Start held high in DONE: capture begins on the next edge.
        #0 start[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("held start en", int'(en[0]), 1);
        checkOutput("held start len cleared", int'(len[0]), 0);
        checkOutput("held start done low", int'(done[0]), 0);
        @(posedge clk); #1 start[0] = 1'b0;
        waitDone(0, gotDone);
        checkOutput("held start done", gotDone, 1);
        checkOutput("held start len", int'(len[0]), 3);

        // Reset in the middle of a capture.
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid capture len", int'(len[0]), 1);
        checkOutput("mid capture cks", int'(cks[0]), 'h48);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checkOutput("mid reset en", int'(en[0]), 0);
        checkOutput("mid reset busy", int'(busy[0]), 0);
        checkOutput("mid reset done", int'(done[0]), 0);
        checkOutput("mid reset len", int'(len[0]), 0);
        checkOutput("mid reset cks", int'(cks[0]), 0);
        checkOutput("mid reset rd", int'(rd[0]), 0);
        checkOutput("mid reset ovf dut2", int'(ovf[2]), 0);
        rdAddr[0] = 8'd1;
        @(posedge clk); #1;
        checkOutput("buffer kept over reset", int'(rd[0]), 'h49);

        // Recapture from length zero after the reset.
        applyStimulus(0, enCnt, busyCnt, gotDone);
        checkOutput("post reset done", gotDone, 1);
        checkOutput("post reset len", int'(len[0]), 3);
        checkOutput("post reset cks", int'(cks[0]), 'hB2);
        checkOutput("post reset en cycles", enCnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
